// File: rtl/vx_perf_dump_ctrl_if.sv
// Dump word stream between the perf dump sequencer and its consumer.
// Signals: dump_valid/ready handshake, dump_data word, dump_id index, dump_last.
interface vx_perf_dump_ctrl_if #(
  parameter int ID_W = 5
);
  logic            dump_valid;
  logic            dump_ready;
  logic [31:0]     dump_data;
  logic [ID_W-1:0] dump_id;
  logic            dump_last;

  modport master (
    output dump_valid,
    input  dump_ready,
    output dump_data,
    output dump_id,
    output dump_last
  );

  modport slave (
    input  dump_valid,
    output dump_ready,
    input  dump_data,
    input  dump_id,
    input  dump_last
  );
endinterface

// File: rtl/vx_perf_dump_ctrl.sv
// Snapshots pipeline perf counters and streams them out as 32-bit words.
// Ports: clk, reset, ctr_in (flattened), start, delta, dump (master), busy, done.
module vx_perf_dump_ctrl #(
  parameter int CTR_BITS = 44,
  parameter int NUM_CTRS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CTRS*CTR_BITS-1:0] ctr_in,
  input  logic                         start,
  input  logic                         delta,
  vx_perf_dump_ctrl_if.master          dump,
  output logic                         busy,
  output logic                         done
);

  localparam int WORDS = (CTR_BITS + 31) / 32;
  localparam int TOTAL = NUM_CTRS * WORDS;
  localparam int ID_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ID_W-1:0]     r_idx;
  logic [CTR_BITS-1:0] r_snap [NUM_CTRS];
  logic [CTR_BITS-1:0] r_prev [NUM_CTRS];
  logic [CTR_BITS-1:0] w_ctr  [NUM_CTRS];
  logic [31:0]         w_words [TOTAL];
  logic                w_send;
  logic                w_fire;
  logic                w_is_last;
  logic                w_capture;

  // Zero-extend each snapshot to whole words, then slice in dump order.
  for (genvar c = 0; c < NUM_CTRS; c++) begin : g_ctr
    logic [WORDS*32-1:0] w_ext;
    assign w_ctr[c] = ctr_in[c*CTR_BITS +: CTR_BITS];
    assign w_ext    = (WORDS*32)'(r_snap[c]);
    for (genvar h = 0; h < WORDS; h++) begin : g_half
      assign w_words[c*WORDS+h] = w_ext[32*h +: 32];
    end
  end

  assign w_send    = (r_state == S_SEND);
  assign w_fire    = w_send && dump.dump_ready;
  assign w_is_last = (r_idx == ID_W'(TOTAL - 1));
  assign w_capture = (r_state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_SEND;
      S_SEND: if (w_fire && w_is_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // prev tracks the last captured raw value in both modes, so a delta
  // dump always reports the change since the previous dump of any kind.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
      for (int i = 0; i < NUM_CTRS; i++) begin
        r_snap[i] <= '0;
        r_prev[i] <= '0;
      end
    end else if (w_capture) begin
      r_idx <= '0;
      for (int i = 0; i < NUM_CTRS; i++) begin
        r_snap[i] <= delta ? (w_ctr[i] - r_prev[i]) : w_ctr[i];
        r_prev[i] <= w_ctr[i];
      end
    end else if (w_fire) begin
      r_idx <= w_is_last ? '0 : r_idx + 1'b1;
    end
  end

  assign dump.dump_valid = w_send;
  assign dump.dump_id    = r_idx;
  assign dump.dump_last  = w_send && w_is_last;
  assign dump.dump_data  = w_send ? w_words[r_idx] : '0;
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_DONE);

endmodule

// File: tb/tb_vx_perf_dump_ctrl.sv
// Directed bench for the perf dump sequencer.
// Each task drives one scenario and checks against hand-derived words.
module tb_vx_perf_dump_ctrl;

  localparam int CB = 44;
  localparam int NC = 10;
  localparam int NW = 20;

  logic            clk;
  logic            reset;
  logic [NC*CB-1:0] ctr_in;
  logic            start;
  logic            delta;
  logic            busy;
  logic            done;

  int tests;
  int fails;

  logic [CB-1:0] mv [NC];
  logic [31:0]   rx [NW];
  logic [4:0]    rxid [NW];

  vx_perf_dump_ctrl_if #(.ID_W(5)) dif ();

  vx_perf_dump_ctrl #(
    .CTR_BITS(CB),
    .NUM_CTRS(NC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctr_in(ctr_in),
    .start (start),
    .delta (delta),
    .dump  (dif),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] wordof(
    input logic [CB-1:0] v,
    input int h
  );
    logic [63:0] x;
    x = {20'b0, v};
    return x[32*h +: 32];
  endfunction

  task automatic load();
    for (int i = 0; i < NC; i++) ctr_in[i*CB +: CB] = mv[i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit d);
    start = 1'b1;
    delta = d;
    step();
    start = 1'b0;
  endtask

  // Gathers the 20 accepted words; optionally scrambles ctr_in each cycle.
  task automatic collect(input int pat, input bit scr);
    int k;
    int n;
    logic [63:0] r;
    k = 0;
    n = 0;
    while (n < NW && k < 200) begin
      dif.dump_ready = (pat == 0) || (k % 3 == 0);
      if (scr) begin
        for (int i = 0; i < NC; i++) begin
          r = {$urandom(), $urandom()};
          ctr_in[i*CB +: CB] = r[CB-1:0];
        end
      end
      #1;
      if (dif.dump_valid && dif.dump_ready) begin
        rx[n]   = dif.dump_data;
        rxid[n] = dif.dump_id;
        n++;
      end
      step();
      k++;
    end
    dif.dump_ready = 1'b1;
    if (n < NW) begin
      tests++;
      fails++;
      $display("FAIL collect_timeout got %0d words want %0d", n, NW);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests++;
    if (dif.dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rst_ctl v=%b b=%b d=%b want 0", dif.dump_valid, busy, done);
    end
    reset = 1'b0;
    step();
    tests++;
    if (dif.dump_id !== 5'd0 || dif.dump_data !== 32'd0 ||
        dif.dump_last !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_out id=%0d data=%h last=%b busy=%b want 0",
               dif.dump_id, dif.dump_data, dif.dump_last, busy);
    end
  endtask

  task automatic test_absolute();
    logic [31:0] e;
    mv[0] = 44'h123_4567_89AB;
    for (int i = 1; i < NC; i++) mv[i] = CB'(i + 1);
    load();
    dif.dump_ready = 1'b1;
    do_start(1'b0);
    for (int w = 0; w < NW; w++) begin
      e = wordof(mv[w/2], w % 2);
      tests++;
      if (dif.dump_valid !== 1'b1 || dif.dump_id !== 5'(w) ||
          dif.dump_data !== e || dif.dump_last !== (w == NW-1) ||
          busy !== 1'b1) begin
        fails++;
        $display("FAIL abs_word%0d v=%b id=%0d data=%h last=%b want id=%0d data=%h",
                 w, dif.dump_valid, dif.dump_id, dif.dump_data,
                 dif.dump_last, w, e);
      end
      if (w == 0 || w == 1 || w == 2 || w == 19) begin
        e = (w == 0) ? 32'h4567_89AB :
            (w == 1) ? 32'h0000_0123 :
            (w == 2) ? 32'h0000_0002 : 32'h0;
        tests++;
        if (dif.dump_data !== e) begin
          fails++;
          $display("FAIL abs_const%0d got %h want %h", w, dif.dump_data, e);
        end
      end
      step();
    end
    tests++;
    if (done !== 1'b1 || dif.dump_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abs_done d=%b v=%b b=%b want 1 0 1", done, dif.dump_valid, busy);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || dif.dump_last !== 1'b0) begin
      fails++;
      $display("FAIL abs_idle d=%b b=%b l=%b want 0", done, busy, dif.dump_last);
    end
  endtask

  task automatic test_backpressure();
    int k;
    int n;
    bit pv;
    bit pr;
    logic [31:0] pd;
    logic [4:0] pid;
    logic [31:0] e;
    for (int i = 0; i < NC; i++) mv[i] = {12'(i + 'h100), 32'(i * 'h0101_0101 + 7)};
    load();
    do_start(1'b0);
    k = 0;
    n = 0;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    pid = '0;
    while (n < NW && k < 200) begin
      dif.dump_ready = (k % 3 == 0);
      #1;
      if (pv && !pr) begin
        tests++;
        if (dif.dump_valid !== 1'b1 || dif.dump_data !== pd || dif.dump_id !== pid) begin
          fails++;
          $display("FAIL bp_stall v=%b id=%0d data=%h want id=%0d data=%h",
                   dif.dump_valid, dif.dump_id, dif.dump_data, pid, pd);
        end
      end
      if (dif.dump_valid && dif.dump_ready) begin
        e = wordof(mv[n/2], n % 2);
        tests++;
        if (dif.dump_id !== 5'(n) || dif.dump_data !== e) begin
          fails++;
          $display("FAIL bp_word id=%0d data=%h want id=%0d data=%h",
                   dif.dump_id, dif.dump_data, n, e);
        end
        n++;
      end
      pv = dif.dump_valid;
      pr = dif.dump_ready;
      pd = dif.dump_data;
      pid = dif.dump_id;
      step();
      k++;
    end
    dif.dump_ready = 1'b1;
    tests++;
    if (n !== NW || done !== 1'b1) begin
      fails++;
      $display("FAIL bp_count n=%0d done=%b want %0d 1", n, done, NW);
    end
    step();
  endtask

  task automatic test_delta();
    for (int i = 0; i < NC; i++) mv[i] = '0;
    mv[6] = 44'd100;
    load();
    do_start(1'b0);
    collect(0, 1'b0);
    step();
    tests++;
    if (rx[12] !== 32'd100 || rx[13] !== 32'd0) begin
      fails++;
      $display("FAIL delta_abs got %h %h want 100 0", rx[12], rx[13]);
    end
    mv[6] = 44'd250;
    load();
    do_start(1'b1);
    collect(0, 1'b0);
    step();
    tests++;
    if (rx[12] !== 32'd150 || rx[13] !== 32'd0 || rx[0] !== 32'd0) begin
      fails++;
      $display("FAIL delta_inc got %0d %0d %0d want 150 0 0", rx[12], rx[13], rx[0]);
    end
    mv[0] = 44'hFFF_FFFF_FFFB;
    load();
    do_start(1'b0);
    collect(0, 1'b0);
    step();
    mv[0] = 44'd3;
    load();
    do_start(1'b1);
    collect(0, 1'b0);
    step();
    tests++;
    if (rx[0] !== 32'd8 || rx[1] !== 32'd0 || rx[12] !== 32'd0) begin
      fails++;
      $display("FAIL delta_wrap got %0d %0d %0d want 8 0 0", rx[0], rx[1], rx[12]);
    end
  endtask

  task automatic test_start_busy();
    for (int i = 0; i < NC; i++) mv[i] = CB'(i * 3);
    load();
    start = 1'b1;
    delta = 1'b0;
    step();
    for (int w = 0; w < NW; w++) begin
      tests++;
      if (dif.dump_valid !== 1'b1 || dif.dump_id !== 5'(w)) begin
        fails++;
        $display("FAIL busy_seq v=%b id=%0d want 1 %0d", dif.dump_valid, dif.dump_id, w);
      end
      step();
    end
    tests++;
    if (done !== 1'b1 || dif.dump_valid !== 1'b0) begin
      fails++;
      $display("FAIL busy_done d=%b v=%b want 1 0", done, dif.dump_valid);
    end
    mv[0] = 44'hABC_DEAD_BEEF;
    load();
    step();
    tests++;
    if (dif.dump_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_idle v=%b b=%b want 0 0", dif.dump_valid, busy);
    end
    step();
    start = 1'b0;
    tests++;
    if (dif.dump_valid !== 1'b1 || dif.dump_id !== 5'd0 ||
        dif.dump_data !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL busy_restart v=%b id=%0d data=%h want 1 0 deadbeef",
               dif.dump_valid, dif.dump_id, dif.dump_data);
    end
    collect(0, 1'b0);
    step();
    tests++;
    if (rx[1] !== 32'h0000_0ABC || rxid[19] !== 5'd19) begin
      fails++;
      $display("FAIL busy_tail got %h id=%0d want abc 19", rx[1], rxid[19]);
    end
  endtask

  task automatic test_snapshot();
    logic [CB-1:0] cap [NC];
    int bad;
    for (int i = 0; i < NC; i++) mv[i] = {12'(i + 5), 32'('h5A5A_0000 + i)};
    for (int i = 0; i < NC; i++) cap[i] = mv[i];
    load();
    do_start(1'b0);
    collect(0, 1'b1);
    step();
    bad = 0;
    for (int w = 0; w < NW; w++) begin
      if (rx[w] !== wordof(cap[w/2], w % 2) || rxid[w] !== 5'(w)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL snap_iso %0d words differ want 0 (w0=%h want %h)",
               bad, rx[0], wordof(cap[0], 0));
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int i = 0; i < NC; i++) mv[i] = {12'(i + 'h30), 32'(i * 1000 + 1)};
    load();
    do_start(1'b0);
    for (int w = 0; w < 7; w++) step();
    tests++;
    if (dif.dump_id !== 5'd7 || dif.dump_valid !== 1'b1) begin
      fails++;
      $display("FAIL rmid_at id=%0d v=%b want 7 1", dif.dump_id, dif.dump_valid);
    end
    reset = 1'b1;
    step();
    tests++;
    if (dif.dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rmid_abort v=%b b=%b d=%b want 0", dif.dump_valid, busy, done);
    end
    reset = 1'b0;
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rmid_nodone d=%b b=%b want 0 0", done, busy);
    end
    do_start(1'b1);
    tests++;
    if (dif.dump_valid !== 1'b1 || dif.dump_id !== 5'd0) begin
      fails++;
      $display("FAIL rmid_first v=%b id=%0d want 1 0", dif.dump_valid, dif.dump_id);
    end
    collect(0, 1'b0);
    step();
    bad = 0;
    for (int w = 0; w < NW; w++) begin
      if (rx[w] !== wordof(mv[w/2], w % 2)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rmid_delta %0d words differ want 0 (w0=%h want %h)",
               bad, rx[0], wordof(mv[0], 0));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    start = 1'b0;
    delta = 1'b0;
    ctr_in = '0;
    dif.dump_ready = 1'b1;
    #1;
    test_reset();
    test_absolute();
    test_backpressure();
    test_delta();
    test_start_busy();
    test_snapshot();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vx_perf_dump_ctrl.md
VX_PERF_DUMP_CTRL -- requirements
Module: VX_perf_dump_ctrl

Interface
REQ-001 SHALL have parameter CTR_BITS, default `PERF_CTR_BITS (44), meaning the width of each pipeline perf counter.
REQ-002 SHALL have parameter NUM_CTRS, default 10, meaning the number of counters sequenced.
REQ-003 SHALL define localparam WORDS = ceil(CTR_BITS/32) (2 at default) and TOTAL = NUM_CTRS*WORDS.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ctr_in  input  NUM_CTRS*CTR_BITS  flattened counters, index 0 in LSBs; order: sched_idles, sched_stalls, ibf_stalls, rf_reads, rf_writes, ifetches, loads, stores, ifetch_latency, load_latency.
REQ-007 start  input  1  dump request pulse or level, sampled only in IDLE.
REQ-008 delta  input  1  sampled with start; 1 = dump increments since previous snapshot, 0 = absolute values.
REQ-009 dump_valid  output  1  dump word valid.
REQ-010 dump_ready  input  1  consumer accepts the word when dump_valid && dump_ready.
REQ-011 dump_data  output  32  current dump word.
REQ-012 dump_id  output  clog2(TOTAL)  word index = counter*WORDS + half.
REQ-013 dump_last  output  1  high with the final word (dump_id == TOTAL-1).
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, DONE.
REQ-017 IDLE: start=1 -> capture snapshot and go to SEND next cycle; start=0 -> stay.
REQ-018 Capture: snap[i] = ctr_in[i] (delta=0) or (ctr_in[i] - prev[i]) mod 2^CTR_BITS (delta=1), sampled in the start cycle; prev[i] <= ctr_in[i] on every capture regardless of mode.
REQ-019 Latency: start in cycle t -> dump_valid=1 with dump_id=0 in cycle t+1.
REQ-020 SEND: dump_valid=1; word w = bits [32*h+31 : 32*h] of snap[c], c = w / WORDS, h = w % WORDS; bits above CTR_BITS zero-filled.
REQ-021 Word order: counter 0 low, counter 0 high, counter 1 low, ..., counter NUM_CTRS-1 high.
REQ-022 dump_data, dump_id and dump_last SHALL hold stable while dump_valid && !dump_ready; dump_valid SHALL not drop before the handshake.
REQ-023 Handshake on a non-final word -> word index increments next cycle; handshake on the final word -> DONE next cycle, dump_valid=0.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; start SHALL be ignored in DONE and SEND (not queued).
REQ-025 ctr_in changes after capture SHALL not affect the dumped words.
REQ-026 dump_valid, dump_last and done SHALL be 0 whenever not in SEND/DONE as specified above.

Reset
REQ-027 reset SHALL force IDLE; dump_valid=0, dump_last=0, done=0, busy=0, dump_id=0, dump_data=0, word index=0, snap=0, prev=0.
REQ-028 reset asserted mid-SEND SHALL abort the dump in the following cycle with no done pulse; the next start after reset SHALL begin at dump_id=0.
REQ-029 First delta dump after reset SHALL equal the absolute values (prev=0).

Verification
REQ-030 Absolute dump: ctr_in[0]=0x123_4567_89AB, others i+1, start, delta=0, dump_ready=1 -> 20 words on consecutive cycles t+1..t+20, word0=0x456789AB, word1=0x00000123, word2=0x00000002, word19=0, dump_last at id 19, done at t+21, busy t+1..t+21.
REQ-031 Backpressure: dump_ready toggled 1,0,0,1,... -> no word lost or duplicated, data/id stable during stalls, dump_id strictly increasing 0..19.
REQ-032 Delta: absolute dump at loads=100, later delta dump at loads=250 -> loads words 150 and 0; delta wrap with prev=2^44-5, cur=3 -> 8.
REQ-033 Start while busy: start held high through SEND and DONE -> exactly one dump in progress; a new capture only from IDLE, first valid 1 cycle after re-entering IDLE with start high.
REQ-034 Reset mid-dump at dump_id=7 -> next cycle dump_valid=0, busy=0, no done; following start yields dump_id=0 and delta equal to absolute.
REQ-035 Snapshot isolation: ctr_in changed every cycle during SEND -> dumped words equal values sampled in the start cycle.
